// File: rtl/cmd_uart_wrapper_if.sv
// Command/response handshake between the UART command link and the command processor.
// The slave modport is the link side; the master modport is the command processor side.
interface cmd_uart_wrapper_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    modport master (
        input  cmd, cmd_rdy, tx_done,
        output clr_cmd_rdy, resp, trmt
    );

    modport slave (
        output cmd, cmd_rdy, tx_done,
        input  clr_cmd_rdy, resp, trmt
    );
endinterface

// File: rtl/cmd_uart_wrapper.sv
// Responder end of the command link: assembles 16-bit commands from two 8N1 bytes (high first)
// and sends single-byte responses; RX and TX engines run independently.
module cmd_uart_wrapper #(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned BYTE_TMO = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    output logic              TX,
    cmd_uart_wrapper_if.slave bus
);
    localparam int unsigned   CW      = $clog2(BAUD_DIV);
    localparam int unsigned   TW      = $clog2(BYTE_TMO + 1);
    localparam logic [CW-1:0] BitEnd  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HalfEnd = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TmoEnd  = TW'(BYTE_TMO - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic       {WaitHi, WaitLo} asm_state_e;

    rx_state_e     rx_state_q;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_byte_rdy_q;

    asm_state_e    asm_state_q;
    logic [7:0]    cmd_hi_q;
    logic [TW-1:0] tmo_cnt_q;

    tx_state_e     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;

    // Synchroniser and edge-detect flops reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= RxIdle;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_byte_rdy_q <= 1'b0;
        end else begin
            rx_meta_q     <= RX;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            rx_byte_rdy_q <= 1'b0;
            case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfEnd) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitEnd) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitEnd) begin
                        rx_cnt_q      <= '0;
                        rx_state_q    <= RxIdle;
                        rx_byte_rdy_q <= rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // A completing low byte sets cmd_rdy even if clr_cmd_rdy arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state_q <= WaitHi;
            cmd_hi_q    <= '0;
            tmo_cnt_q   <= '0;
            bus.cmd     <= '0;
            bus.cmd_rdy <= 1'b0;
        end else begin
            if (bus.clr_cmd_rdy) bus.cmd_rdy <= 1'b0;
            case (asm_state_q)
                WaitHi: begin
                    if (rx_byte_rdy_q) begin
                        cmd_hi_q    <= rx_shift_q;
                        tmo_cnt_q   <= '0;
                        bus.cmd_rdy <= 1'b0;
                        asm_state_q <= WaitLo;
                    end
                end
                WaitLo: begin
                    if (rx_byte_rdy_q) begin
                        bus.cmd     <= {cmd_hi_q, rx_shift_q};
                        bus.cmd_rdy <= 1'b1;
                        asm_state_q <= WaitHi;
                    end else if (tmo_cnt_q == TmoEnd) begin
                        asm_state_q <= WaitHi;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: asm_state_q <= WaitHi;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            TX          <= 1'b1;
            bus.tx_done <= 1'b0;
        end else begin
            case (tx_state_q)
                TxIdle: begin
                    if (bus.trmt) begin
                        tx_shift_q  <= bus.resp;
                        bus.tx_done <= 1'b0;
                        TX          <= 1'b0;
                        tx_cnt_q    <= '0;
                        tx_state_q  <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == BitEnd) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        TX         <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == BitEnd) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            TX         <= 1'b1;
                            tx_state_q <= TxStop;
                        end else begin
                            TX         <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == BitEnd) begin
                        tx_cnt_q    <= '0;
                        bus.tx_done <= 1'b1;
                        tx_state_q  <= TxIdle;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Scoreboard bench for cmd_uart_wrapper: expected commands and TX bytes are queued by the
// stimulus and consumed by independent monitors on cmd_rdy rises and TX frames.
module tb_cmd_uart_wrapper;
    localparam int unsigned B   = 16;
    localparam int unsigned TMO = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx;

    cmd_uart_wrapper_if bus ();

    cmd_uart_wrapper #(
        .BAUD_DIV (B),
        .BYTE_TMO (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx),
        .TX    (tx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        rdy_prev = 1'b0;
    logic        rst_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(B);
        end
        rx = stop;
        tick(B);
        rx = 1'b1;
        tick(2);
    endtask

    task automatic send_cmd(input logic [15:0] c);
        exp_cmd_q.push_back(c);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
    endtask

    task automatic pulse_trmt(input logic [7:0] r);
        bus.resp = r;
        bus.trmt = 1'b1;
        tick(1);
        bus.trmt = 1'b0;
    endtask

    // Command monitor: every rising cmd_rdy must match the next queued command.
    always @(negedge clk) begin
        if (bus.cmd_rdy && !rdy_prev) begin
            if (exp_cmd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cmd_unexpected: got 0x%0h, expected no command", bus.cmd);
            end else begin
                check("cmd_value", {16'h0, bus.cmd}, {16'h0, exp_cmd_q.pop_front()});
            end
        end
        rdy_prev = bus.cmd_rdy;
    end

    always @(negedge rst_n) rst_seen = 1'b1;

    // TX monitor: decodes each frame at mid-bit; frames cut by reset are dropped.
    initial begin
        logic [7:0] d;
        logic       sb;
        logic       st;
        forever begin
            @(negedge tx);
            rst_seen = 1'b0;
            repeat (B / 2) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(negedge clk);
                d[i] = tx;
            end
            repeat (B) @(negedge clk);
            sb = tx;
            if (!rst_seen) begin
                if (exp_tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no frame", d);
                end else begin
                    check("tx_start", {31'h0, st}, 32'h0);
                    check("tx_byte", {24'h0, d}, {24'h0, exp_tx_q.pop_front()});
                    check("tx_stop", {31'h0, sb}, 32'h1);
                end
            end
        end
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [9:0] exp_bits;
        bus.clr_cmd_rdy = 1'b0;
        bus.trmt        = 1'b0;
        bus.resp        = 8'h00;
        tick(3);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_cmd", {16'h0, bus.cmd}, 32'h0);
        check("rst_cmd_rdy", {31'h0, bus.cmd_rdy}, 32'h0);
        check("rst_tx_done", {31'h0, bus.tx_done}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        send_cmd(16'h2F34);
        tick(2);
        check("rdy_after_2f34", {31'h0, bus.cmd_rdy}, 32'h1);
        check("cmd_2f34", {16'h0, bus.cmd}, 32'h2F34);
        bus.clr_cmd_rdy = 1'b1;
        tick(1);
        bus.clr_cmd_rdy = 1'b0;
        check("rdy_cleared", {31'h0, bus.cmd_rdy}, 32'h0);
        check("cmd_held", {16'h0, bus.cmd}, 32'h2F34);

        send_cmd(16'h0000);
        exp_cmd_q.push_back(16'h6123);
        send_byte(8'h61, 1'b1);
        check("rdy_drop_on_hi", {31'h0, bus.cmd_rdy}, 32'h0);
        check("cmd_hold_0000", {16'h0, bus.cmd}, 32'h0000);
        send_byte(8'h23, 1'b1);
        check("rdy_6123", {31'h0, bus.cmd_rdy}, 32'h1);

        // clr_cmd_rdy held across the low byte: the set must still win for one cycle.
        exp_cmd_q.push_back(16'h4BC1);
        send_byte(8'h4B, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        send_byte(8'hC1, 1'b1);
        bus.clr_cmd_rdy = 1'b0;
        check("cmd_4bc1", {16'h0, bus.cmd}, 32'h4BC1);
        check("rdy_clr_after_set", {31'h0, bus.cmd_rdy}, 32'h0);

        // TX frame 0xA5 with a second trmt (0x5A) mid-frame that must be ignored.
        exp_bits = {1'b1, 8'hA5, 1'b0};
        exp_tx_q.push_back(8'hA5);
        pulse_trmt(8'hA5);
        check("tx_done_clr", {31'h0, bus.tx_done}, 32'h0);
        tick(B / 2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {31'h0, tx}, {31'h0, exp_bits[i]});
            if (i == 4) begin
                pulse_trmt(8'h5A);
                tick(B - 1);
            end else if (i < 9) begin
                tick(B);
            end
        end
        check("tx_done_early", {31'h0, bus.tx_done}, 32'h0);
        tick(B / 2 - 1);
        check("tx_done_edge_minus1", {31'h0, bus.tx_done}, 32'h0);
        tick(1);
        check("tx_done_set", {31'h0, bus.tx_done}, 32'h1);
        tick(3 * B);
        check("tx_done_hold", {31'h0, bus.tx_done}, 32'h1);

        // Response sent while a command is being received.
        exp_tx_q.push_back(8'hC3);
        pulse_trmt(8'hC3);
        check("tx_done_clr2", {31'h0, bus.tx_done}, 32'h0);
        send_cmd(16'h0A0B);
        check("tx_done_c3", {31'h0, bus.tx_done}, 32'h1);

        // Framing error on a would-be high byte.
        send_byte(8'hAB, 1'b0);
        tick(B);
        check("cmd_after_frame_err", {16'h0, bus.cmd}, 32'h0A0B);
        send_cmd(16'h1234);

        // Low byte too late: high byte 0x55 must be dropped.
        send_byte(8'h55, 1'b1);
        tick(TMO + 10);
        send_cmd(16'h1234);

        // Glitch shorter than half a bit.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(3 * B);
        send_cmd(16'h9A0F);

        // Reset in the middle of an RX low byte and a TX frame.
        send_byte(8'h77, 1'b1);
        pulse_trmt(8'h00);
        rx = 1'b0;
        tick(B);
        rx = 1'b1;
        tick(2 * B);
        check("tx_low_before_rst", {31'h0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", {31'h0, tx}, 32'h1);
        check("rst_mid_cmd_rdy", {31'h0, bus.cmd_rdy}, 32'h0);
        check("rst_mid_cmd", {16'h0, bus.cmd}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(4 * B);
        send_cmd(16'hBEEF);
        tick(4 * B);

        check("cmd_queue_empty", exp_cmd_q.size(), 32'h0);
        check("tx_queue_empty", exp_tx_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
